// File: rtl/cnn_top_mac_acc.sv
// Accumulates TERMS consecutive unsigned products into one window sum and holds it in a
// single-entry valid/ready output register. Define CNN_ACC_SAT_EN to saturate instead of wrap.
module cnn_top_mac_acc #(
    parameter int PROD_WIDTH = 9,
    parameter int ACC_WIDTH  = 16,
    parameter int TERMS      = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  acc_ovf
);

    localparam int CNT_W = $clog2(TERMS + 1);
    localparam int EXT_W = ACC_WIDTH + 1 - PROD_WIDTH;
    localparam logic [CNT_W-1:0]   LAST     = CNT_W'(TERMS - 1);
    localparam logic [ACC_WIDTH:0] ALL_ONES = {1'b0, {ACC_WIDTH{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               state_r, state_nxt;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt;
    logic [ACC_WIDTH:0]   acc_r, acc_nxt;
    logic [ACC_WIDTH:0]   base, sum, result;
    logic                 ovf_r, ovf_nxt, win_ovf;
    logic                 last_term, take, final_take;

    // Only the final term can stall, and only while the held result is not being drained.
    assign last_term  = (cnt_r == LAST);
    assign prod_ready = !(last_term && acc_valid && !acc_ready);
    assign take       = prod_valid && prod_ready;
    assign final_take = take && last_term;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            acc_r   <= acc_nxt;
            ovf_r   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        acc_nxt   = acc_r;
        ovf_nxt   = ovf_r;
        base      = (state_r == ACCUM) ? acc_r : '0;
        sum       = base + {{EXT_W{1'b0}}, prod_data};
        win_ovf   = ((state_r == ACCUM) && ovf_r) || sum[ACC_WIDTH];
        result    = {1'b0, sum[ACC_WIDTH-1:0]};
`ifdef CNN_ACC_SAT_EN
        if (win_ovf) begin
            result = ALL_ONES;
        end
`endif
        if (take) begin
            if (last_term) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                acc_nxt   = '0;
                ovf_nxt   = 1'b0;
            end else begin
                state_nxt = ACCUM;
                cnt_nxt   = cnt_r + 1'b1;
                acc_nxt   = result;
                ovf_nxt   = win_ovf;
            end
        end
    end

    // A final term arriving while the old result drains simply reloads the register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_valid <= 1'b0;
            acc_data  <= '0;
            acc_ovf   <= 1'b0;
        end else if (final_take) begin
            acc_valid <= 1'b1;
            acc_data  <= result[ACC_WIDTH-1:0];
            acc_ovf   <= win_ovf;
        end else if (acc_valid && acc_ready) begin
            acc_valid <= 1'b0;
        end
    end

endmodule
